// File: rtl/hd_transfer_ctrl.sv
// HD <-> data memory block transfer sequencer.
// One word per REQ/STORE pair; pronto pulses once at the end.
module hd_transfer_ctrl #(
  parameter int DATA_W     = 32,
  parameter int HD_ADDR_W  = 12,
  parameter int MEM_ADDR_W = 10,
  parameter int LEN_W      = 8,
  parameter int HD_LAT     = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            op_hd,
  input  logic [HD_ADDR_W-1:0]  hd_base,
  input  logic [MEM_ADDR_W-1:0] mem_base,
  input  logic [LEN_W-1:0]      xfer_len,
  input  logic [DATA_W-1:0]     hd_rdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [HD_ADDR_W-1:0]  hd_addr,
  output logic [DATA_W-1:0]     hd_wdata,
  output logic                  hd_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  pronto,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, RD_STORE,
    WR_REQ, WR_STORE, DONE
  } state_t;

  localparam int WW = (HD_LAT > 2) ? $clog2(HD_LAT) : 1;
  localparam logic [WW-1:0] WINIT =
    WW'((HD_LAT > 1) ? HD_LAT - 2 : 0);

  state_t                  state;
  logic [LEN_W:0]          cnt;
  logic [LEN_W:0]          cnt_nx;
  logic [LEN_W-1:0]        len_r;
  logic [HD_ADDR_W-1:0]    hbase;
  logic [MEM_ADDR_W-1:0]   mbase;
  logic [WW-1:0]           wcnt;
  logic                    last;

  assign cnt_nx = cnt + (LEN_W+1)'(1);
  assign last   = (cnt_nx == {1'b0, len_r});

  // Read data is only valid in the STORE cycle, so pass it through
  // under the registered strobe.
  assign mem_wdata = mem_we ? hd_rdata  : '0;
  assign hd_wdata  = hd_we  ? mem_rdata : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      len_r    <= '0;
      hbase    <= '0;
      mbase    <= '0;
      wcnt     <= '0;
      hd_addr  <= '0;
      mem_addr <= '0;
      hd_we    <= 1'b0;
      mem_we   <= 1'b0;
      busy     <= 1'b0;
      pronto   <= 1'b0;
      err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          hd_we  <= 1'b0;
          mem_we <= 1'b0;
          pronto <= 1'b0;
          err    <= 1'b0;
          if (op_hd != 2'd0) begin
            hbase <= hd_base;
            mbase <= mem_base;
            len_r <= xfer_len;
            cnt   <= '0;
            busy  <= 1'b1;
            if (op_hd == 2'd3) begin
              state  <= DONE;
              pronto <= 1'b1;
              err    <= 1'b1;
            end else if (xfer_len == '0) begin
              state  <= DONE;
              pronto <= 1'b1;
            end else if (op_hd == 2'd1) begin
              state   <= RD_REQ;
              hd_addr <= hd_base;
            end else begin
              state    <= WR_REQ;
              mem_addr <= mem_base;
            end
          end
        end
        RD_REQ: begin
          if (HD_LAT == 1) begin
            state    <= RD_STORE;
            mem_we   <= 1'b1;
            mem_addr <= mbase + MEM_ADDR_W'(cnt);
          end else begin
            state <= RD_WAIT;
            wcnt  <= WINIT;
          end
        end
        RD_WAIT: begin
          if (wcnt == '0) begin
            state    <= RD_STORE;
            mem_we   <= 1'b1;
            mem_addr <= mbase + MEM_ADDR_W'(cnt);
          end else begin
            wcnt <= wcnt - WW'(1);
          end
        end
        RD_STORE: begin
          mem_we <= 1'b0;
          if (last) begin
            state  <= DONE;
            pronto <= 1'b1;
          end else begin
            cnt     <= cnt_nx;
            state   <= RD_REQ;
            hd_addr <= hbase + HD_ADDR_W'(cnt_nx);
          end
        end
        WR_REQ: begin
          state   <= WR_STORE;
          hd_we   <= 1'b1;
          hd_addr <= hbase + HD_ADDR_W'(cnt);
        end
        WR_STORE: begin
          hd_we <= 1'b0;
          if (last) begin
            state  <= DONE;
            pronto <= 1'b1;
          end else begin
            cnt      <= cnt_nx;
            state    <= WR_REQ;
            mem_addr <= mbase + MEM_ADDR_W'(cnt_nx);
          end
        end
        DONE: begin
          state  <= IDLE;
          pronto <= 1'b0;
          err    <= 1'b0;
          busy   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hd_transfer_ctrl.sv
// Directed bench for hd_transfer_ctrl.
// Two instances: HD_LAT=2 (main) and HD_LAT=1 (back-to-back reads).
module tb_hd_transfer_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]  op_hd = '0;
  logic [11:0] hd_base = '0;
  logic [9:0]  mem_base = '0;
  logic [7:0]  xfer_len = '0;
  logic [31:0] hd_rdata, mem_rdata;
  logic [11:0] hd_addr;
  logic [31:0] hd_wdata;
  logic        hd_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we, busy, pronto, err;

  logic [1:0]  op2 = '0;
  logic [11:0] hb2 = '0;
  logic [9:0]  mb2 = '0;
  logic [7:0]  len2 = '0;
  logic [31:0] hd_rdata2, mem_rdata2;
  logic [11:0] hd_addr2;
  logic [31:0] hd_wdata2;
  logic        hd_we2;
  logic [9:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic        mem_we2, busy2, pronto2, err2;

  hd_transfer_ctrl #(.HD_LAT(2)) dut (
    .clock(clock), .reset(reset), .op_hd(op_hd),
    .hd_base(hd_base), .mem_base(mem_base),
    .xfer_len(xfer_len), .hd_rdata(hd_rdata),
    .mem_rdata(mem_rdata), .hd_addr(hd_addr),
    .hd_wdata(hd_wdata), .hd_we(hd_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .busy(busy), .pronto(pronto),
    .err(err)
  );

  hd_transfer_ctrl #(.HD_LAT(1)) dut1 (
    .clock(clock), .reset(reset), .op_hd(op2),
    .hd_base(hb2), .mem_base(mb2),
    .xfer_len(len2), .hd_rdata(hd_rdata2),
    .mem_rdata(mem_rdata2), .hd_addr(hd_addr2),
    .hd_wdata(hd_wdata2), .hd_we(hd_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_we(mem_we2), .busy(busy2), .pronto(pronto2),
    .err(err2)
  );

  // HD/memory models; contents reload to a known pattern under reset
  logic [31:0] hd   [0:4095];
  logic [31:0] mem  [0:1023];
  logic [31:0] mem2 [0:1023];
  logic [31:0] p0;

  always @(posedge clock) begin
    p0         <= hd[hd_addr];
    hd_rdata   <= p0;
    mem_rdata  <= mem[mem_addr];
    hd_rdata2  <= hd[hd_addr2];
    mem_rdata2 <= mem2[mem_addr2];
    if (!reset) begin
      for (int i = 0; i < 4096; i++) hd[i] = 32'hA000_0000 | i;
      for (int i = 0; i < 1024; i++) begin
        mem[i]  = 32'hB000_0000 | i;
        mem2[i] = 32'hC000_0000 | i;
      end
    end else begin
      if (hd_we)   hd[hd_addr]     = hd_wdata;
      if (mem_we)  mem[mem_addr]   = mem_wdata;
      if (mem_we2) mem2[mem_addr2] = mem_wdata2;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [1:0] op,
                       input logic [11:0] hb,
                       input logic [9:0] mb,
                       input logic [7:0] len);
    @(negedge clock);
    op_hd = op; hd_base = hb; mem_base = mb; xfer_len = len;
  endtask

  task automatic run_xfer(input int budget, output int pc,
                          output logic perr, output int nbusy,
                          output int nstr, output int nover,
                          output logic busy_after);
    pc = 0; perr = 1'b0; nbusy = 0; nstr = 0; nover = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clock);
      if (c == 1) op_hd = 2'd0;
      if (busy) nbusy++;
      if (hd_we || mem_we) nstr++;
      if (hd_we && mem_we) nover++;
      if (pronto) begin
        pc = c; perr = err;
        break;
      end
    end
    @(negedge clock);
    busy_after = busy;
  endtask

  int pc, nb, ns, no, p1, p2, np, cw, ch;
  logic pe, ba;

  initial begin
    repeat (3) @(negedge clock);
    check("rst_flags", {busy, pronto, err, hd_we, mem_we}, 64'h0);
    check("rst_addr", {hd_addr, mem_addr}, 64'h0);
    check("rst_wdata", {hd_wdata, mem_wdata}, 64'h0);
    reset = 1'b1;
    @(negedge clock);

    // read 4 words, HD_LAT=2
    start(2'd1, 12'h010, 10'h020, 8'd4);
    run_xfer(40, pc, pe, nb, ns, no, ba);
    check("rd_pronto_cyc", pc, 13);
    check("rd_err", pe, 0);
    check("rd_busy_cycles", nb, 13);
    check("rd_busy_after", ba, 0);
    check("rd_strobes", ns, 4);
    check("rd_overlap", no, 0);
    check("rd_mem20", mem[10'h020], 32'hA000_0010);
    check("rd_mem21", mem[10'h021], 32'hA000_0011);
    check("rd_mem22", mem[10'h022], 32'hA000_0012);
    check("rd_mem23", mem[10'h023], 32'hA000_0013);
    check("rd_mem24", mem[10'h024], 32'hB000_0024);

    // write 3 words with wrap on both address spaces
    start(2'd2, 12'hFFF, 10'h3FE, 8'd3);
    run_xfer(40, pc, pe, nb, ns, no, ba);
    check("wr_pronto_cyc", pc, 7);
    check("wr_strobes", ns, 3);
    check("wr_overlap", no, 0);
    check("wr_hdFFF", hd[12'hFFF], 32'hB000_03FE);
    check("wr_hd000", hd[12'h000], 32'hB000_03FF);
    check("wr_hd001", hd[12'h001], 32'hB000_0000);
    check("wr_hd002", hd[12'h002], 32'hA000_0002);

    // zero length and illegal op
    start(2'd1, 12'h100, 10'h100, 8'd0);
    run_xfer(10, pc, pe, nb, ns, no, ba);
    check("len0_pronto_cyc", pc, 1);
    check("len0_err", pe, 0);
    check("len0_strobes", ns, 0);
    check("len0_busy_after", ba, 0);
    start(2'd3, 12'h100, 10'h100, 8'd5);
    run_xfer(10, pc, pe, nb, ns, no, ba);
    check("op3_pronto_cyc", pc, 1);
    check("op3_err", pe, 1);
    check("op3_strobes", ns, 0);

    // reset during RD_WAIT of word 2 of 4
    start(2'd1, 12'h010, 10'h040, 8'd4);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      if (c == 1) op_hd = 2'd0;
    end
    check("abort_busy_pre", busy, 1);
    reset = 1'b0;
    @(negedge clock);
    check("abort_flags", {busy, pronto, err, hd_we, mem_we}, 64'h0);
    check("abort_addr", {hd_addr, mem_addr}, 64'h0);
    check("abort_wdata", {hd_wdata, mem_wdata}, 64'h0);
    reset = 1'b1;
    cw = 0; np = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (mem_we || hd_we) cw++;
      if (pronto) np++;
    end
    check("abort_no_strobe", cw, 0);
    check("abort_no_pronto", np, 0);
    check("abort_mem41", mem[10'h041], 32'hB000_0041);

    // op held through DONE; hd_base changed mid-transfer
    start(2'd1, 12'h020, 10'h080, 8'd1);
    p1 = 0; p2 = 0; np = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (c == 2) hd_base = 12'h021;
      if (c == 6) op_hd = 2'd0;
      if (c == 4) check("hold_mem80_a", mem[10'h080], 32'hA000_0020);
      if (c == 5) check("hold_idle_busy", busy, 0);
      if (pronto) begin
        np++;
        if (p1 == 0) p1 = c;
        else if (p2 == 0) p2 = c;
      end
    end
    check("hold_pronto1", p1, 4);
    check("hold_pronto2", p2, 9);
    check("hold_npulses", np, 2);
    check("hold_mem80_b", mem[10'h080], 32'hA000_0021);

    // back-to-back single-word reads, HD_LAT=1
    @(negedge clock);
    op2 = 2'd1; hb2 = 12'h030; mb2 = 10'h050; len2 = 8'd1;
    p1 = 0; p2 = 0; np = 0; no = 0; cw = 0; ch = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (c == 5) op2 = 2'd0;
      if (hd_we2 && mem_we2) no++;
      if (mem_we2) cw++;
      if (hd_we2) ch++;
      if (pronto2) begin
        np++;
        if (p1 == 0) p1 = c;
        else if (p2 == 0) p2 = c;
      end
    end
    check("b2b_pronto1", p1, 3);
    check("b2b_pronto2", p2, 7);
    check("b2b_npulses", np, 2);
    check("b2b_overlap", no, 0);
    check("b2b_mem_we", cw, 2);
    check("b2b_hd_we", ch, 0);
    check("b2b_mem50", mem2[10'h050], 32'hA000_0030);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
